// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier and the ALU result mux.
// State encodings, default widths and the MULT op code.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_XOR  = 4'h2,
    ALU_MULT = 4'h3
  } alu_op_t;

  function automatic logic is_mult(input alu_op_t op);
    return op == ALU_MULT;
  endfunction

endpackage

// File: rtl/mult32_control.sv
// Control FSM and iteration counter for mult32_seq.
// Emits load/shift_en strobes plus registered busy/done.
module mult32_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  mult_state_t      state;
  logic [CNT_W-1:0] cnt;

  assign load     = (state == IDLE) && start;
  assign shift_en = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + ONE;
          // last iteration happens on this edge
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult32_seq.sv
// Multi-cycle unsigned shift-add multiplier, one iteration per clock.
// Holds the M/P registers and the carry-keeping adder.
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               load;
  logic               shift_en;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  mult32_control #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load     (load),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    addend = p_q[0] ? m_q : '0;
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q <= '0;
      p_q <= '0;
    end else if (load) begin
      m_q <= a;
      p_q <= {{WIDTH{1'b0}}, b};
    end else if (shift_en) begin
      // carry out of the add lands in the product MSB
      p_q <= {sum, p_q[WIDTH-1:1]};
    end
  end

  assign product = p_q;

endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Multi-cycle unsigned shift-add multiplier for the ALU datapath.
- Sits alongside the 32-bit bitwise units (and/or/xor) and feeds the ALU result mux; the mux selects its 64-bit product for MULT-class ops.
- Split into a registered datapath and a small control FSM, in the same datapath/control style as the rest of the ALU.
- One clock; synchronous active-low reset.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
- b  input  WIDTH  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result; holds last value until next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, counter=0, multiplicand reg=0, product reg=0.
  - busy=0, done=0, product=0.
  - Reset wins over every other event, including mid-RUN and a simultaneous start.
- States:
  - IDLE: start=1 -> M<=a, P<={WIDTH'b0, b}, cnt<=0, go RUN.
  - RUN: one iteration per cycle. When cnt==WIDTH-1 after the update, go DONE.
  - DONE: done=1 for exactly this cycle, then go IDLE unconditionally.
- Iteration (RUN, per clk):
  - sum = {1'b0, P[2W-1:W]} + (P[0] ? M : 0), a (W+1)-bit add that keeps the carry.
  - P <= {sum, P[W-1:1]}, i.e. right shift by 1 with the carry entering the MSB.
  - cnt <= cnt+1.
- Latency:
  - start accepted at edge E0; RUN occupies cycles 1..WIDTH (32 edges).
  - done=1 in cycle WIDTH+1 (33 for default).
  - First new start can be accepted at the edge following the DONE cycle.
- start handling:
  - Ignored in RUN and DONE: no restart, operands not re-latched.
  - start held high continuously issues back-to-back multiplies, one every WIDTH+2 cycles.
- Operand capture: a/b may change freely after acceptance; the result reflects the captured values only.
- product output:
  - Driven directly from the P register.
  - Intermediate values are visible during RUN; consumers must qualify with done or !busy.
  - After DONE, P holds until the next accepted start or reset.
- Overflow: none. The 2W-bit product is exact for all unsigned inputs, and the carry is never dropped.
- Zero operands: no early termination. Always WIDTH iterations, for deterministic latency.

Decomposition:
- Shared package mult_pkg:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10 (2'b11 illegal -> IDLE).
  - default WIDTH.
  - ALU op code for MULT used by the result mux.
- One sub-module, mult32_control:
  - Holds the FSM and counter.
  - Emits load, shift_en, done, busy.
  - Datapath registers and the adder stay in mult32_seq.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1, a=7, b=9 -> busy=0, done=0, product=0; no operation starts.
- Basic: a=3, b=5, start pulse at cycle 0 -> busy=1 cycles 1..33, done=1 only in cycle 33, product=64'h0000_0000_0000_000F, held afterward.
- Max operands: a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 at done; exercises the carry into bit 63.
- Zero/one: a=0, b=32'hDEAD_BEEF -> product=0 at cycle 33. Then a=1, b=32'hDEAD_BEEF -> product=64'h0000_0000_DEAD_BEEF.
- Busy protection: start a=6, b=7; at cycle 10 assert start with a=100, b=100 and change a/b -> done at cycle 33 with product=42; no second done follows.
- Reset mid-op: start a=12345, b=678; rst_n=0 at cycle 15 for one cycle -> next cycle busy=0, product=0, done never pulses. A new start afterward with a=2, b=2 yields product=4 exactly 33 cycles later.
